mpmc11_to_watchdog: RTL and testbench

- Consumes the memory-controller state stream and acts on stalled states: counts cycles spent in one non-IDLE state and, at a programmable limit, requests an abort from the controller FSM over a req/ack handshake.
- Latches the stuck state and keeps a saturating timeout-event count for debug.
- Sits beside the controller FSM, downstream of its state register, upstream of its abort/recovery logic.

---
 rtl/mpmc11_to_watchdog.sv | 157 +++++++++++++++
 tb/tb_mpmc11_to_watchdog.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc11_to_watchdog.sv
// mpmc11_to_watchdog: dwell-time watchdog on the memory-controller state stream.
// Counts cycles spent in one non-IDLE state and, at a programmable limit, raises
// an abort request that must be acknowledged, then holds off for HOLDOFF cycles.
// Optional feature macro: MPMC11_TO_IRQ_EN (sticky timeout interrupt on irq).

package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACT     = 3'd1,
    READ    = 3'd2,
    WRITE   = 3'd3,
    PRECHG  = 3'd4,
    REFRESH = 3'd5
  } mpmc11_state_t;
endpackage

module mpmc11_to_watchdog
  import mpmc11_pkg::*;
#(
  parameter int unsigned CNT_BITS = 16,
  parameter int unsigned HOLDOFF  = 8,
  parameter int unsigned EVT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  mpmc11_state_t       state,
  input  logic [CNT_BITS-1:0] limit,
  output logic                abort_req,
  input  logic                abort_ack,
  input  logic                clr_stat,
  output mpmc11_state_t       stuck_state,
  output logic [EVT_BITS-1:0] to_evt_cnt,
  output logic [CNT_BITS-1:0] dwell,
  output logic                irq
);

  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_WATCH = 2'd0,
    ST_ABORT = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_t;

  fsm_t              r_fsm;
  fsm_t              w_fsm_nxt;
  mpmc11_state_t     r_prev_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_abort_nxt;
  logic              w_held;
  logic              w_timeout;

  // A state counts as held when it is non-IDLE and unchanged from last cycle
  assign w_held = (state != IDLE) && (state == r_prev_state);

  // Equality-only compare: lowering limit below the running dwell never fires
  assign w_timeout = (r_fsm == ST_WATCH) && (limit != '0) && w_held &&
                     (dwell == (limit - CNT_BITS'(1)));

  // FSM state register and holdoff counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_WATCH;
      r_hold_cnt <= '0;
      abort_req  <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_hold_cnt <= w_hold_nxt;
      abort_req  <= w_abort_nxt;
    end
  end

  // Next-state: request stays up until acknowledged, then a fixed holdoff window
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_hold_nxt  = r_hold_cnt;
    w_abort_nxt = abort_req;
    case (r_fsm)
      ST_WATCH: begin
        if (w_timeout) begin
          w_fsm_nxt   = ST_ABORT;
          w_abort_nxt = 1'b1;
        end
      end
      ST_ABORT: begin
        if (abort_ack) begin
          w_fsm_nxt   = ST_HOLD;
          w_abort_nxt = 1'b0;
          w_hold_nxt  = HOLD_W'(HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_fsm_nxt = ST_WATCH;
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        w_fsm_nxt   = ST_WATCH;
        w_abort_nxt = 1'b0;
      end
    endcase
  end

  // Previous-state tracker and saturating dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_state <= IDLE;
      dwell        <= '0;
    end else begin
      r_prev_state <= state;
      if ((r_fsm != ST_WATCH) || !w_held) begin
        dwell <= '0;
      end else if (dwell != '1) begin
        dwell <= dwell + CNT_BITS'(1);
      end
    end
  end

  // Debug capture: stuck state and saturating event count (timeout beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_state <= IDLE;
      to_evt_cnt  <= '0;
    end else begin
      if (w_timeout) begin
        stuck_state <= state;
        if (clr_stat) begin
          to_evt_cnt <= EVT_BITS'(1);
        end else if (to_evt_cnt != '1) begin
          to_evt_cnt <= to_evt_cnt + EVT_BITS'(1);
        end
      end else if (clr_stat) begin
        to_evt_cnt <= '0;
      end
    end
  end

`ifdef MPMC11_TO_IRQ_EN
  // Sticky interrupt set alongside the abort request; set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (w_timeout) begin
      irq <= 1'b1;
    end else if (clr_stat) begin
      irq <= 1'b0;
    end
  end
`else
  // Interrupt not built
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mpmc11_to_watchdog.sv
// Self-checking bench for mpmc11_to_watchdog: a cycle-level reference model is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_mpmc11_to_watchdog;
  import mpmc11_pkg::*;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned EVT_W = 8;
  localparam int DWELL_SAT = (1 << CNT_W) - 1;
  localparam int EVT_SAT   = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  mpmc11_state_t    state = IDLE;
  logic [CNT_W-1:0] limit = '0;
  logic             abort_ack = 1'b0;
  logic             clr_stat = 1'b0;
  logic             abort_req;
  mpmc11_state_t    stuck_state;
  logic [EVT_W-1:0] to_evt_cnt;
  logic [CNT_W-1:0] dwell;
  logic             irq;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
`ifdef MPMC11_TO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  mpmc11_to_watchdog #(
    .CNT_BITS(CNT_W),
    .HOLDOFF (HOLD),
    .EVT_BITS(EVT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .limit      (limit),
    .abort_req  (abort_req),
    .abort_ack  (abort_ack),
    .clr_stat   (clr_stat),
    .stuck_state(stuck_state),
    .to_evt_cnt (to_evt_cnt),
    .dwell      (dwell),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases plus an unbounded run length and an absolute release edge
  typedef enum int {P_WATCH, P_ABORT, P_HOLD} phase_t;
  phase_t        m_phase = P_WATCH;
  int            m_run = 0;
  int            m_edge = 0;
  int            m_release = 0;
  int            m_evt = 0;
  bit            m_irq = 1'b0;
  mpmc11_state_t m_prev = IDLE;
  mpmc11_state_t m_stuck = IDLE;

  always @(posedge clk or negedge rst_n) begin
    bit fire;
    bit held;
    if (!rst_n) begin
      m_phase = P_WATCH;
      m_run   = 0;
      m_evt   = 0;
      m_irq   = 1'b0;
      m_prev  = IDLE;
      m_stuck = IDLE;
    end else begin
      m_edge++;
      held = (m_phase == P_WATCH) && (state != IDLE) && (state == m_prev);
      fire = held && (limit != 0) && (m_run == int'(limit) - 1);
      m_run = held ? m_run + 1 : 0;
      case (m_phase)
        P_WATCH: if (fire) m_phase = P_ABORT;
        P_ABORT: if (abort_ack) begin
          m_phase   = P_HOLD;
          m_release = m_edge + int'(HOLD);
        end
        default: if (m_edge == m_release) m_phase = P_WATCH;
      endcase
      if (fire) begin
        m_stuck = state;
        m_evt   = clr_stat ? 1 : ((m_evt < EVT_SAT) ? m_evt + 1 : EVT_SAT);
        m_irq   = 1'b1;
      end else if (clr_stat) begin
        m_evt = 0;
        m_irq = 1'b0;
      end
      m_prev = state;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("abort_req", int'(abort_req), int'(m_phase == P_ABORT));
      chk("stuck_state", int'(stuck_state), int'(m_stuck));
      chk("to_evt_cnt", int'(to_evt_cnt), m_evt);
      chk("dwell", int'(dwell), (m_run > DWELL_SAT) ? DWELL_SAT : m_run);
      chk("irq", int'(irq), IRQ_ON ? int'(m_irq) : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!abort_req && n < 60) begin
      tick(1);
      n++;
    end
    chk("wait_req", int'(abort_req), 1);
  endtask

  initial begin
    // Reset values
    tick(2);
    chk("rst_abort", int'(abort_req), 0);
    chk("rst_stuck", int'(stuck_state), int'(IDLE));
    chk("rst_evt", int'(to_evt_cnt), 0);
    chk("rst_dwell", int'(dwell), 0);
    chk("rst_irq", int'(irq), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick(1);

    // Held state: timeout on the 17th edge, ack, holdoff, second timeout 24 later
    limit = CNT_W'(16);
    state = ACT;
    tick(16);
    chk("s1_pre_abort", int'(abort_req), 0);
    chk("s1_pre_dwell", int'(dwell), 15);
    tick(1);
    chk("s1_abort", int'(abort_req), 1);
    chk("s1_stuck", int'(stuck_state), int'(ACT));
    chk("s1_evt", int'(to_evt_cnt), 1);
    chk("s1_irq", int'(irq), int'(IRQ_ON));
    tick(3);
    chk("s1_hold_req", int'(abort_req), 1);
    abort_ack = 1'b1;
    tick(1);
    abort_ack = 1'b0;
    chk("s1_ack_drop", int'(abort_req), 0);
    tick(23);
    chk("s1_no_early", int'(abort_req), 0);
    chk("s1_evt_still", int'(to_evt_cnt), 1);
    tick(1);
    chk("s1_second", int'(abort_req), 1);
    chk("s1_evt2", int'(to_evt_cnt), 2);
    abort_ack = 1'b1;
    tick(1);
    abort_ack = 1'b0;
    state = IDLE;
    tick(10);
    clr_stat = 1'b1;
    tick(1);
    clr_stat = 1'b0;
    chk("s1_clr_evt", int'(to_evt_cnt), 0);
    chk("s1_clr_irq", int'(irq), 0);

    // State changes every 10 cycles: no timeout, stray acks ignored
    for (int i = 0; i < 6; i++) begin
      state = (i % 2 == 0) ? WRITE : READ;
      abort_ack = 1'b1;
      tick(1);
      abort_ack = 1'b0;
      tick(9);
      chk("s2_dwell9", int'(dwell), 9);
      chk("s2_no_abort", int'(abort_req), 0);
    end
    state = IDLE;
    tick(2);

    // limit=0: dwell saturates, no timeout; lowering limit below dwell stays silent
    limit = '0;
    state = REFRESH;
    tick(5000);
    chk("s3_sat", int'(dwell), DWELL_SAT);
    chk("s3_abort", int'(abort_req), 0);
    chk("s3_evt", int'(to_evt_cnt), 0);
    limit = CNT_W'(100);
    tick(200);
    chk("s3_low_limit", int'(abort_req), 0);
    state = IDLE;
    tick(2);

    // 300 timeouts saturate the event count; clear coincident with a timeout gives 1
    limit = CNT_W'(1);
    state = ACT;
    for (int i = 0; i < 300; i++) begin
      wait_req();
      abort_ack = 1'b1;
      tick(1);
      abort_ack = 1'b0;
    end
    chk("s4_evt_sat", int'(to_evt_cnt), EVT_SAT);
    tick(8);
    chk("s4_pre_fire", int'(abort_req), 0);
    clr_stat = 1'b1;
    tick(1);
    clr_stat = 1'b0;
    chk("s4_clr_fire_evt", int'(to_evt_cnt), 1);
    chk("s4_clr_fire_req", int'(abort_req), 1);
    chk("s4_clr_fire_irq", int'(irq), int'(IRQ_ON));

    // Asynchronous reset while in ABORT
    rst_n = 1'b0;
    #1;
    chk("s5_async_req", int'(abort_req), 0);
    chk("s5_async_evt", int'(to_evt_cnt), 0);
    chk("s5_async_irq", int'(irq), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("s5_watch_req", int'(abort_req), 1);
    chk("s5_watch_evt", int'(to_evt_cnt), 1);
    chk("s5_watch_stuck", int'(stuck_state), int'(ACT));
    abort_ack = 1'b1;
    tick(1);
    abort_ack = 1'b0;
    state = IDLE;
    tick(12);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
